// File: rtl/fetch_pc_unit.sv
// Fetch / PC stage: owns the PC, fetches words over req/ack, hands them to decode.
// Optional ack watchdog (fault_o) is built when FETCH_TIMEOUT_EN is defined.
module fetch_pc_unit #(
    parameter logic [15:0] RESET_PC       = 16'h0000,
    parameter logic [15:0] PC_STEP        = 16'd1,
    parameter int          INSTR_WIDTH    = 32,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    input  logic                   shouldBranch_i,
    input  logic                   branchDirection_i,
    input  logic [15:0]            branchOffset_i,
    input  logic                   flush_i,
    input  logic                   imemAck_i,
    input  logic [INSTR_WIDTH-1:0] imemData_i,
    input  logic                   stall_i,
    output logic                   imemReq_o,
    output logic [15:0]            imemAddr_o,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [15:0]            instrPc_o,
    output logic                   instrValid_o,
`ifdef FETCH_TIMEOUT_EN
    output logic                   fault_o,
`endif
    output logic [15:0]            pc_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t state;

    logic [15:0] target;
    logic [15:0] pc_next;
    logic        kill;

    always_comb begin
        target  = branchDirection_i ? (pc_o + branchOffset_i)
                                    : (pc_o - branchOffset_i);
        pc_next = shouldBranch_i ? target : pc_o;
        kill    = shouldBranch_i | flush_i;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state        <= IDLE;
            pc_o         <= RESET_PC;
            imemReq_o    <= 1'b0;
            imemAddr_o   <= RESET_PC;
            instr_o      <= '0;
            instrPc_o    <= '0;
            instrValid_o <= 1'b0;
        end else begin
            pc_o <= pc_next;
            if (kill) instrValid_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (enable_i) begin
                        state      <= REQ;
                        imemReq_o  <= 1'b1;
                        imemAddr_o <= pc_next;
                    end
                end
                REQ: begin
                    if (imemAck_i && !kill) begin
                        instr_o      <= imemData_i;
                        instrPc_o    <= imemAddr_o;
                        instrValid_o <= 1'b1;
                        pc_o         <= pc_o + PC_STEP;
                        imemReq_o    <= 1'b0;
                        state        <= HOLD;
                    end else if (imemAck_i) begin
                        // wrong-path data: drop it and refetch at the new PC
                        if (enable_i) begin
                            state      <= REQ;
                            imemReq_o  <= 1'b1;
                            imemAddr_o <= pc_next;
                        end else begin
                            state     <= IDLE;
                            imemReq_o <= 1'b0;
                        end
                    end else if (kill) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (imemAck_i) begin
                        if (enable_i) begin
                            state      <= REQ;
                            imemReq_o  <= 1'b1;
                            imemAddr_o <= pc_next;
                        end else begin
                            state     <= IDLE;
                            imemReq_o <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (kill || !stall_i) begin
                        instrValid_o <= 1'b0;
                        if (enable_i) begin
                            state      <= REQ;
                            imemReq_o  <= 1'b1;
                            imemAddr_o <= pc_next;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wait_cnt;

    // counts cycles an outstanding request has waited; fault is sticky
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wait_cnt <= '0;
            fault_o  <= 1'b0;
        end else if ((state == REQ || state == DRAIN) && !imemAck_i) begin
            if (wait_cnt != TW'(TIMEOUT_CYCLES))
                wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == TW'(TIMEOUT_CYCLES - 1))
                fault_o <= 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end
`endif

endmodule
